// File: rtl/systolic_pkg.sv
// Shared systolic-array types and constants, used by the MAC array and the psum drain.
package systolic_pkg;
  localparam int P_BITWIDTH = 24;
  localparam int ROW_CNT_W  = 16;
  typedef logic [P_BITWIDTH-1:0] psum_t;
endpackage

// File: rtl/psum_drain_if.sv
// Column-input / row-output stream bundle of the psum drain.
interface psum_drain_if #(
  parameter int COLS       = 4,
  parameter int P_BITWIDTH = systolic_pkg::P_BITWIDTH
);
  import systolic_pkg::*;

  logic [COLS-1:0]            col_valid;
  logic [COLS*P_BITWIDTH-1:0] col_psum;
  logic                       out_valid;
  logic                       out_ready;
  logic [COLS*P_BITWIDTH-1:0] out_data;
  logic                       almost_full;
  logic                       overflow;
  logic [ROW_CNT_W-1:0]       row_cnt;

  modport master (
    output col_valid, col_psum, out_ready,
    input  out_valid, out_data, almost_full, overflow, row_cnt
  );

  modport slave (
    input  col_valid, col_psum, out_ready,
    output out_valid, out_data, almost_full, overflow, row_cnt
  );
endinterface

// File: rtl/psum_col_fifo.sv
// Single-column synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module psum_col_fifo #(
  parameter int P_BITWIDTH = systolic_pkg::P_BITWIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [P_BITWIDTH-1:0]   din,
  input  logic                    pop,
  output logic [P_BITWIDTH-1:0]   dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [P_BITWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/psum_drain.sv
// De-skews bottom-row partial sums into whole rows on a valid/ready stream.
// Optional macro PSUM_DRAIN_RELU_EN clamps negative output slices to zero on the read path.
module psum_drain #(
  parameter int COLS       = 4,
  parameter int P_BITWIDTH = systolic_pkg::P_BITWIDTH,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  psum_drain_if.slave bus
);
  import systolic_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [COLS-1:0]       push, full, empty;
  logic [CW-1:0]         count [COLS];
  logic [P_BITWIDTH-1:0] head  [COLS];
  logic                  row_vld, pop;
  logic                  almost_full_q, almost_full_d;
  logic                  overflow_q, overflow_d;
  logic [ROW_CNT_W-1:0]  row_cnt_q, row_cnt_d;

  assign push    = bus.col_valid;
  assign row_vld = &(~empty);
  assign pop     = row_vld & bus.out_ready;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    psum_col_fifo #(
      .P_BITWIDTH (P_BITWIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[c]),
      .din   (bus.col_psum[c*P_BITWIDTH +: P_BITWIDTH]),
      .pop   (pop),
      .dout  (head[c]),
      .count (count[c]),
      .full  (full[c]),
      .empty (empty[c])
    );
  end

  // Status looks ahead to the post-edge counts so almost_full is timely for the controller.
  always_comb begin
    int cnt_nxt;
    cnt_nxt       = 0;
    almost_full_d = 1'b0;
    overflow_d    = overflow_q;
    row_cnt_d     = row_cnt_q + ROW_CNT_W'(pop);
    for (int c = 0; c < COLS; c++) begin
      cnt_nxt = int'(count[c]) + int'(push[c] & (~full[c] | pop)) - int'(pop);
      if (cnt_nxt >= AF_THRESH) almost_full_d = 1'b1;
      if (push[c] && full[c] && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      row_cnt_q     <= '0;
    end else begin
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      row_cnt_q     <= row_cnt_d;
    end
  end

  always_comb begin
    logic [P_BITWIDTH-1:0] slice;
    slice        = '0;
    bus.out_data = '0;
    for (int c = 0; c < COLS; c++) begin
      slice = row_vld ? head[c] : '0;
`ifdef PSUM_DRAIN_RELU_EN
      if (slice[P_BITWIDTH-1]) slice = '0;
`endif
      bus.out_data[c*P_BITWIDTH +: P_BITWIDTH] = slice;
    end
  end

  assign bus.out_valid   = row_vld;
  assign bus.almost_full = almost_full_q;
  assign bus.overflow    = overflow_q;
  assign bus.row_cnt     = row_cnt_q;
endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: directed scenarios plus random traffic against a queue-based row model.
module tb_psum_drain;
  import systolic_pkg::*;

  localparam int COLS  = 4;
  localparam int PW    = 24;
  localparam int DEPTH = 4;
  localparam int AF    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_drain_if #(.COLS(COLS), .P_BITWIDTH(PW)) bus ();

  psum_drain #(
    .COLS       (COLS),
    .P_BITWIDTH (PW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  psum_t mq [COLS][$];
  logic  m_ovf;
  int    m_rows;

  function automatic psum_t relu(input psum_t v);
`ifdef PSUM_DRAIN_RELU_EN
    if ($signed(v) < 0) return '0;
`endif
    return v;
  endfunction

  function automatic logic m_valid();
    for (int c = 0; c < COLS; c++)
      if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_af();
    for (int c = 0; c < COLS; c++)
      if (mq[c].size() >= AF) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [COLS-1:0] v, input logic [COLS*PW-1:0] d, input logic r);
    if (rst) begin
      for (int c = 0; c < COLS; c++) mq[c].delete();
      m_ovf  = 1'b0;
      m_rows = 0;
    end else begin
      if (m_valid() && r) begin
        for (int c = 0; c < COLS; c++) void'(mq[c].pop_front());
        m_rows = (m_rows + 1) % 65536;
      end
      for (int c = 0; c < COLS; c++) begin
        if (v[c]) begin
          if (mq[c].size() < DEPTH) mq[c].push_back(d[c*PW +: PW]);
          else m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic compare(input string tag);
    logic [COLS*PW-1:0] exp_data;
    exp_data = '0;
    if (m_valid())
      for (int c = 0; c < COLS; c++) exp_data[c*PW +: PW] = relu(mq[c][0]);
    chk({tag, ".out_valid"},   bus.out_valid,   m_valid());
    chk({tag, ".out_data"},    bus.out_data,    exp_data);
    chk({tag, ".almost_full"}, bus.almost_full, m_af());
    chk({tag, ".overflow"},    bus.overflow,    m_ovf);
    chk({tag, ".row_cnt"},     bus.row_cnt,     m_rows[15:0]);
  endtask

  task automatic step(input string tag, input logic [COLS-1:0] v,
                      input logic [COLS*PW-1:0] d, input logic r);
    bus.col_valid = v;
    bus.col_psum  = d;
    bus.out_ready = r;
    @(posedge clk);
    model_edge(v, d, r);
    #1;
    compare(tag);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step("rst", '0, '0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [COLS-1:0]    v;
    logic [COLS*PW-1:0] d;

    rst           = 1'b1;
    bus.col_valid = '0;
    bus.col_psum  = '0;
    bus.out_ready = 1'b0;
    m_ovf         = 1'b0;
    m_rows        = 0;

    step("reset", '0, '0, 1'b0);
    step("reset", '0, '0, 1'b0);
    chk("reset_valid_zero", bus.out_valid, 1'b0);
    chk("reset_data_zero",  bus.out_data,  '0);
    rst = 1'b0;

    // Skewed single row: column c arrives at cycle c
    for (int t = 0; t < COLS; t++) begin
      d = '0;
      d[t*PW +: PW] = PW'(100 + t);
      v = COLS'(1 << t);
      step("skew", v, d, 1'b1);
    end
    chk("skew_row_const", bus.out_data, {24'd103, 24'd102, 24'd101, 24'd100});
    step("skew_pop", '0, '0, 1'b1);
    chk("skew_row_cnt_const", bus.row_cnt, 16'd1);
    chk("skew_valid_gone",    bus.out_valid, 1'b0);

    // Back-pressure: four skewed rows, then an extra column-0 push
    pulse_reset();
    for (int t = 0; t < COLS + 3; t++) begin
      v = '0;
      d = '0;
      for (int c = 0; c < COLS; c++) begin
        if (t - c >= 0 && t - c <= 3) begin
          v[c] = 1'b1;
          d[c*PW +: PW] = PW'(10 * (t - c) + c);
        end
      end
      step("bp_fill", v, d, 1'b0);
      if (t == 1) chk("bp_af_const", bus.almost_full, 1'b1);
    end
    step("bp_ovf", 4'b0001, {4{24'd99}}, 1'b0);
    chk("bp_ovf_const", bus.overflow, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("bp_row_const", bus.out_data,
          {PW'(10 * k + 3), PW'(10 * k + 2), PW'(10 * k + 1), PW'(10 * k)});
      step("bp_drain", '0, '0, 1'b1);
    end
    chk("bp_rows_const",   bus.row_cnt,  16'd4);
    chk("bp_ovf_sticky",   bus.overflow, 1'b1);

    // Full FIFOs with simultaneous push and pop
    pulse_reset();
    for (int k = 0; k < DEPTH; k++)
      step("full_fill", 4'b1111, {4{PW'(k + 1)}}, 1'b0);
    step("full_pp", 4'b1111, {4{24'd55}}, 1'b1);
    chk("full_pp_no_ovf", bus.overflow, 1'b0);
    chk("full_pp_af",     bus.almost_full, 1'b1);
    for (int k = 0; k < DEPTH; k++)
      step("full_drain", '0, '0, 1'b1);
    chk("full_last_rows", bus.row_cnt, 16'd5);

    // Reset mid-operation
    pulse_reset();
    step("mid_fill", 4'b1111, {4{24'd7}}, 1'b0);
    step("mid_fill", 4'b1111, {4{24'd8}}, 1'b0);
    step("mid_part", 4'b0011, {4{24'd9}}, 1'b0);
    pulse_reset();
    chk("mid_valid_const", bus.out_valid, 1'b0);
    chk("mid_rows_const",  bus.row_cnt,   16'd0);
    step("mid_fresh", 4'b1111, {24'd4, 24'd3, 24'd2, 24'd1}, 1'b0);
    chk("mid_fresh_const", bus.out_data, {24'd4, 24'd3, 24'd2, 24'd1});

    // Signed slices through the optional clamp
    pulse_reset();
    step("relu", 4'b1111, {24'h000010, 24'hFFFFF6, 24'h000010, 24'hFFFFF6}, 1'b0);
`ifdef PSUM_DRAIN_RELU_EN
    chk("relu_const", bus.out_data, {24'h000010, 24'h000000, 24'h000010, 24'h000000});
`else
    chk("relu_const", bus.out_data, {24'h000010, 24'hFFFFF6, 24'h000010, 24'hFFFFF6});
`endif
    step("relu_pop", '0, '0, 1'b1);

    // Random traffic with occasional resets
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      step("rand", COLS'($urandom), {$urandom, $urandom, $urandom},
           $urandom_range(0, 3) != 0);
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
